// File: rtl/dbus_responder.sv
// dbus_responder: data-bus target with a word-organised RAM and a fixed
// access latency. Each accepted load/store produces exactly one ready pulse,
// carrying either the full read word or an error flag.
module dbus_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dbus_addr,
    input  logic [31:0] dbus_wdata,
    input  logic [3:0]  dbus_be,
    input  logic        dbus_we,
    input  logic        dbus_re,
    output logic [31:0] dbus_rdata,
    output logic        dbus_ready,
    output logic        dbus_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = $clog2(LATENCY + 1);
    // Window size in bytes, held in 33 bits so a window ending exactly at
    // 2^32 never wraps the upper-bound compare.
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          accept;

    // Request decode, evaluated on the live inputs and latched on acceptance
    logic [31:0]   offset;
    logic          lo_viol;
    logic          hi_viol;
    logic          req_err;

    // Latched transaction: control bits are reset, data payload is not
    logic          lat_we;
    logic          lat_re;
    logic          lat_err;
    logic [AW-1:0] lat_idx;
    logic [31:0]   lat_wdata;
    logic [3:0]    lat_be;

    logic [31:0]   mem [DEPTH_WORDS];

    assign offset  = dbus_addr - BASE_ADDR;
    assign lo_viol = (dbus_addr < BASE_ADDR);
    assign hi_viol = ({1'b0, offset} >= SPAN);
    assign req_err = lo_viol | hi_viol | (dbus_we & dbus_re)
                   | (dbus_we & (dbus_be == 4'b0000));

    // Next-state and counter logic; inputs only matter while IDLE
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (dbus_we | dbus_re) begin
                    accept    = 1'b1;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and latency counter; async reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Latch request kind and error decision on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we  <= 1'b0;
            lat_re  <= 1'b0;
            lat_err <= 1'b0;
        end else if (accept) begin
            lat_we  <= dbus_we;
            lat_re  <= dbus_re;
            lat_err <= req_err;
        end
    end

    // Latch the request payload; only meaningful together with the control bits
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_idx   <= offset[AW+1:2];
            lat_wdata <= dbus_wdata;
            lat_be    <= dbus_be;
        end
    end

    // Commit a valid store on the edge that ends RESP; a reset before that
    // edge moves the FSM to IDLE and so discards the store
    always_ff @(posedge clk) begin
        if ((state == RESP) && lat_we && !lat_err) begin
            for (int k = 0; k < 4; k++) begin
                if (lat_be[k]) begin
                    mem[lat_idx][8*k +: 8] <= lat_wdata[8*k +: 8];
                end
            end
        end
    end

    // Outputs decode from state so a reset clears them without waiting for clk
    always_comb begin
        dbus_ready = (state == RESP);
        dbus_err   = dbus_ready & lat_err;
        dbus_rdata = 32'h0;
        if (dbus_ready && lat_re && !lat_err) begin
            dbus_rdata = mem[lat_idx];
        end
    end

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder: one instance at LATENCY=2 with the
// default window, one at LATENCY=1 whose window ends exactly at 2^32.
module tb_dbus_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_be;
    logic        a_we, a_re, a_ready, a_err;

    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_be;
    logic        b_we, b_re, b_ready, b_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dbus_responder #(
        .DEPTH_WORDS(1024),
        .LATENCY    (2),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dbus_addr (a_addr),
        .dbus_wdata(a_wdata),
        .dbus_be   (a_be),
        .dbus_we   (a_we),
        .dbus_re   (a_re),
        .dbus_rdata(a_rdata),
        .dbus_ready(a_ready),
        .dbus_err  (a_err)
    );

    dbus_responder #(
        .DEPTH_WORDS(16),
        .LATENCY    (1),
        .BASE_ADDR  (32'hFFFF_FFC0)
    ) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .dbus_addr (b_addr),
        .dbus_wdata(b_wdata),
        .dbus_be   (b_be),
        .dbus_we   (b_we),
        .dbus_re   (b_re),
        .dbus_rdata(b_rdata),
        .dbus_ready(b_ready),
        .dbus_err  (b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One LATENCY=2 transaction: accept, one WAIT cycle, RESP, back to IDLE
    task automatic txn2(input string tag, input logic we, input logic re,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input logic exp_err,
                        input logic [31:0] exp_rd);
        a_we = we; a_re = re; a_addr = addr; a_wdata = wd; a_be = be;
        tick();
        a_we = 1'b0; a_re = 1'b0;
        chk({tag, ".wait_ready"}, 32'(a_ready), 32'h0);
        chk({tag, ".wait_rdata"}, a_rdata, 32'h0);
        tick();
        chk({tag, ".ready"}, 32'(a_ready), 32'h1);
        chk({tag, ".err"}, 32'(a_err), 32'(exp_err));
        chk({tag, ".rdata"}, a_rdata, exp_rd);
        tick();
        chk({tag, ".idle_ready"}, 32'(a_ready), 32'h0);
    endtask

    // One LATENCY=1 transaction: RESP directly after the acceptance edge
    task automatic txn1(input string tag, input logic we, input logic re,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input logic exp_err,
                        input logic [31:0] exp_rd);
        b_we = we; b_re = re; b_addr = addr; b_wdata = wd; b_be = be;
        tick();
        b_we = 1'b0; b_re = 1'b0;
        chk({tag, ".ready"}, 32'(b_ready), 32'h1);
        chk({tag, ".err"}, 32'(b_err), 32'(exp_err));
        chk({tag, ".rdata"}, b_rdata, exp_rd);
        tick();
        chk({tag, ".idle_ready"}, 32'(b_ready), 32'h0);
    endtask

    initial begin
        a_addr = '0; a_wdata = '0; a_be = '0; a_we = 1'b0; a_re = 1'b0;
        b_addr = '0; b_wdata = '0; b_be = '0; b_we = 1'b0; b_re = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst.ready", 32'(a_ready), 32'h0);
        chk("rst.err", 32'(a_err), 32'h0);
        chk("rst.rdata", a_rdata, 32'h0);
        chk("rst.b_ready", 32'(b_ready), 32'h0);
        rst_n = 1'b1;
        tick();

        // Full store then load
        txn2("st10", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
        txn2("ld10", 1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);

        // Partial store into byte lane 1 only
        txn2("st10p", 1'b1, 1'b0, 32'h10, 32'h0000AA00, 4'b0010, 1'b0, 32'h0);
        txn2("ld10p", 1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADAAEF);

        // Last word in range, first word out of range, store with no lanes
        txn2("stFFC", 1'b1, 1'b0, 32'hFFC, 32'hA5A5A5A5, 4'hF, 1'b0, 32'h0);
        txn2("ldFFC", 1'b0, 1'b1, 32'hFFC, 32'h0, 4'h0, 1'b0, 32'hA5A5A5A5);
        txn2("ld1000", 1'b0, 1'b1, 32'h1000, 32'h0, 4'h0, 1'b1, 32'h0);
        txn2("st20", 1'b1, 1'b0, 32'h20, 32'h12345678, 4'hF, 1'b0, 32'h0);
        txn2("st20be0", 1'b1, 1'b0, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b1, 32'h0);
        txn2("ld20", 1'b0, 1'b1, 32'h20, 32'h0, 4'h0, 1'b0, 32'h12345678);

        // Store and load both requested together
        txn2("st08", 1'b1, 1'b0, 32'h8, 32'h0BADF00D, 4'hF, 1'b0, 32'h0);
        txn2("we_re08", 1'b1, 1'b1, 32'h8, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0);
        txn2("ld08", 1'b0, 1'b1, 32'h8, 32'h0, 4'h0, 1'b0, 32'h0BADF00D);

        // Reset during WAIT discards the pending store
        txn2("st40", 1'b1, 1'b0, 32'h40, 32'h11111111, 4'hF, 1'b0, 32'h0);
        a_we = 1'b1; a_addr = 32'h40; a_wdata = 32'h22222222; a_be = 4'hF;
        tick();
        a_we = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstwait.ready", 32'(a_ready), 32'h0);
        chk("rstwait.err", 32'(a_err), 32'h0);
        chk("rstwait.rdata", a_rdata, 32'h0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("rstwait.no_resp", 32'(a_ready), 32'h0);
        tick();
        chk("rstwait.no_resp2", 32'(a_ready), 32'h0);
        txn2("ld40", 1'b0, 1'b1, 32'h40, 32'h0, 4'h0, 1'b0, 32'h11111111);

        // Reset during RESP clears outputs without waiting for a clock edge
        a_re = 1'b1; a_addr = 32'h40;
        tick();
        a_re = 1'b0;
        tick();
        chk("rstresp.pre_ready", 32'(a_ready), 32'h1);
        chk("rstresp.pre_rdata", a_rdata, 32'h11111111);
        rst_n = 1'b0;
        #1;
        chk("rstresp.ready", 32'(a_ready), 32'h0);
        chk("rstresp.rdata", a_rdata, 32'h0);
        #1;
        rst_n = 1'b1;
        tick();

        // LATENCY=1, window ending at 2^32
        txn1("b_stTop", 1'b1, 1'b0, 32'hFFFF_FFFC, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0);
        txn1("b_ldTop", 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D);
        txn1("b_ldBelow", 1'b0, 1'b1, 32'hFFFF_FFBC, 32'h0, 4'h0, 1'b1, 32'h0);
        txn1("b_ld0", 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0);
        txn1("b_stBase", 1'b1, 1'b0, 32'hFFFF_FFC0, 32'h5A5A0001, 4'hF, 1'b0, 32'h0);

        // Held load request: re-accepted every other edge, never two readies in a row
        b_re = 1'b1; b_addr = 32'hFFFF_FFC0;
        chk("hold.pre", 32'(b_ready), 32'h0);
        tick();
        chk("hold.c1", 32'(b_ready), 32'h1);
        chk("hold.c1_rdata", b_rdata, 32'h5A5A0001);
        tick();
        chk("hold.c2", 32'(b_ready), 32'h0);
        tick();
        chk("hold.c3", 32'(b_ready), 32'h1);
        tick();
        chk("hold.c4", 32'(b_ready), 32'h0);
        tick();
        chk("hold.c5", 32'(b_ready), 32'h1);
        b_re = 1'b0;
        tick();
        chk("hold.c6", 32'(b_ready), 32'h0);
        tick();
        chk("hold.c7", 32'(b_ready), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
